// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock design: glyph codes, the
// enrollment state encoding, password width and the display helpers.
package lock_pkg;

  localparam int PW_W = 10;

  localparam logic [3:0] GLY_P     = 4'd10;
  localparam logic [3:0] GLY_A     = 4'd11;
  localparam logic [3:0] GLY_F     = 4'd12;
  localparam logic [3:0] GLY_L     = 4'd13;
  localparam logic [3:0] GLY_BLANK = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER1 = 2'd1,
    ENTER2 = 2'd2,
    RESULT = 2'd3
  } state_t;

  // Index 5 is display5 (leftmost digit), index 0 is display0.
  typedef logic [5:0][3:0] disp_t;

  localparam disp_t DISP_BLANK = {6{GLY_BLANK}};
  localparam disp_t DISP_PASS  = {GLY_BLANK, GLY_BLANK, GLY_P, GLY_A, 4'd5, 4'd5};
  localparam disp_t DISP_FAIL  = {GLY_BLANK, GLY_BLANK, GLY_F, GLY_A, 4'd1, GLY_L};

  // Entry screen: phase number, blank, hundreds split into two digits
  // (h only reaches 10), tens, ones.
  function automatic disp_t disp_enter(input logic [3:0] phase,
                                       input logic [3:0] h,
                                       input logic [3:0] t,
                                       input logic [3:0] o);
    disp_t d;
    d[5] = phase;
    d[4] = GLY_BLANK;
    d[3] = (h == 4'd10) ? 4'd1 : 4'd0;
    d[2] = (h == 4'd10) ? 4'd0 : h;
    d[1] = t;
    d[0] = o;
    return d;
  endfunction

endpackage

// File: rtl/key_pulse.sv
// Push-button front end: two-flop synchronizer followed by a saturating
// hold counter. Emits exactly one single-cycle pulse per press, on the
// HOLD_CYCLES-th consecutive low synchronized sample.
module key_pulse #(
  parameter int HOLD_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic key,
  output logic pulse
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_ARM = CNT_W'(HOLD_CYCLES - 1);

  logic             key_m;
  logic             key_s;
  logic [CNT_W-1:0] hold_cnt;

  // Synchronizer; resets to the released (high) level so reset cannot fake a press.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
    end else begin
      key_m <= key;
      key_s <= key_m;
    end
  end

  // Hold counter saturates at HOLD_CYCLES; pulse fires only on the step into saturation.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      pulse    <= 1'b0;
    end else begin
      pulse <= !key_s && (hold_cnt == HOLD_ARM);
      if (key_s) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pw_enroll.sv
// Password enrollment controller: the user enters a three-digit code twice;
// a matching pair within 10 bits is committed to pw.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for key3 with enroll_en high, displays blank
//   ENTER1 | first entry of the code, digits editable
//   ENTER2 | confirmation entry, digits editable
//   RESULT | PASS/FAIL shown for RESULT_CYCLES, keys ignored
module pw_enroll
  import lock_pkg::*;
#(
  parameter int HOLD_CYCLES   = 500000,
  parameter int RESULT_CYCLES = 100000000
) (
  input  logic            CLOCK_50,
  input  logic            reset_n,
  input  logic            key0,
  input  logic            key1,
  input  logic            key2,
  input  logic            key3,
  input  logic            enroll_en,
  output logic [PW_W-1:0] pw,
  output logic            pw_valid,
  output logic            busy,
  output logic [3:0]      display5,
  output logic [3:0]      display4,
  output logic [3:0]      display3,
  output logic [3:0]      display2,
  output logic [3:0]      display1,
  output logic [3:0]      display0
);

  localparam int RES_W = $clog2(RESULT_CYCLES + 1);
  localparam logic [RES_W-1:0] RES_LOAD = RES_W'(RESULT_CYCLES - 1);

  state_t           state;
  logic [3:0]       ev;
  logic [3:0]       h, t, o;
  logic [3:0]       h_nx, t_nx, o_nx;
  logic [3:0]       phase;
  logic [10:0]      value;
  logic [10:0]      first;
  logic [RES_W-1:0] res_cnt;
  disp_t            disp;

  key_pulse #(.HOLD_CYCLES(HOLD_CYCLES)) u_key0 (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .key(key0), .pulse(ev[0]));
  key_pulse #(.HOLD_CYCLES(HOLD_CYCLES)) u_key1 (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .key(key1), .pulse(ev[1]));
  key_pulse #(.HOLD_CYCLES(HOLD_CYCLES)) u_key2 (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .key(key2), .pulse(ev[2]));
  key_pulse #(.HOLD_CYCLES(HOLD_CYCLES)) u_key3 (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .key(key3), .pulse(ev[3]));

  // Candidate digit values; only taken in the entry states when key3 is not firing.
  assign h_nx  = ev[2] ? ((h == 4'd10) ? 4'd0 : h + 4'd1) : h;
  assign t_nx  = ev[1] ? ((t == 4'd9)  ? 4'd0 : t + 4'd1) : t;
  assign o_nx  = ev[0] ? ((o == 4'd9)  ? 4'd0 : o + 4'd1) : o;
  assign phase = (state == ENTER1) ? 4'd1 : 4'd2;
  assign value = 11'(h) * 11'd100 + 11'(t) * 11'd10 + 11'(o);

  // Enrollment FSM with digit registers, password register and display mux.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      h        <= 4'd0;
      t        <= 4'd0;
      o        <= 4'd0;
      first    <= 11'd0;
      pw       <= '0;
      pw_valid <= 1'b0;
      busy     <= 1'b0;
      res_cnt  <= '0;
      disp     <= DISP_BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (ev[3] && enroll_en) begin
            state <= ENTER1;
            h     <= 4'd0;
            t     <= 4'd0;
            o     <= 4'd0;
            busy  <= 1'b1;
            disp  <= disp_enter(4'd1, 4'd0, 4'd0, 4'd0);
          end
        end

        ENTER1, ENTER2: begin
          if (!enroll_en) begin
            state <= IDLE;
            busy  <= 1'b0;
            disp  <= DISP_BLANK;
          end else if (ev[3]) begin
            // Commit uses the digits as they stand; a same-cycle digit event is dropped.
            if (state == ENTER1) begin
              first <= value;
              if (value > 11'd1023) begin
                state   <= RESULT;
                res_cnt <= RES_LOAD;
                disp    <= DISP_FAIL;
              end else begin
                state <= ENTER2;
                h     <= 4'd0;
                t     <= 4'd0;
                o     <= 4'd0;
                disp  <= disp_enter(4'd2, 4'd0, 4'd0, 4'd0);
              end
            end else begin
              if (value == first) begin
                pw       <= first[PW_W-1:0];
                pw_valid <= 1'b1;
                disp     <= DISP_PASS;
              end else begin
                disp     <= DISP_FAIL;
              end
              state   <= RESULT;
              res_cnt <= RES_LOAD;
            end
          end else begin
            h    <= h_nx;
            t    <= t_nx;
            o    <= o_nx;
            disp <= disp_enter(phase, h_nx, t_nx, o_nx);
          end
        end

        RESULT: begin
          if (res_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            disp  <= DISP_BLANK;
          end else begin
            res_cnt <= res_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign display5 = disp[5];
  assign display4 = disp[4];
  assign display3 = disp[3];
  assign display2 = disp[2];
  assign display1 = disp[1];
  assign display0 = disp[0];

endmodule

// File: tb/tb_pw_enroll.sv
// Self-checking bench for pw_enroll: a directed table of key presses with
// hand-derived expected outputs, then randomized key activity, all checked
// every cycle against a behavioural model of the enrollment rules.
module tb_pw_enroll;

  localparam int HOLD = 4;
  localparam int RES  = 8;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       key0 = 1'b1, key1 = 1'b1, key2 = 1'b1, key3 = 1'b1;
  logic       enroll_en = 1'b0;
  logic [9:0] pw;
  logic       pw_valid, busy;
  logic [3:0] display5, display4, display3, display2, display1, display0;

  pw_enroll #(.HOLD_CYCLES(HOLD), .RESULT_CYCLES(RES)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n),
    .key0(key0), .key1(key1), .key2(key2), .key3(key3),
    .enroll_en(enroll_en), .pw(pw), .pw_valid(pw_valid), .busy(busy),
    .display5(display5), .display4(display4), .display3(display3),
    .display2(display2), .display1(display1), .display0(display0));

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_cyc    = 0;

  // ---- behavioural model ----
  int         m_phase;   // 0 idle, 1 first entry, 2 confirm, 3 showing result
  int         m_h, m_t, m_o, m_first, m_pw, m_dwell;
  bit         m_pwv, m_pass;
  int         run[4];
  logic [3:0] ev_q[$];

  function automatic logic [23:0] dsp(input int a, input int b, input int c,
                                      input int d, input int e, input int f);
    return {4'(a), 4'(b), 4'(c), 4'(d), 4'(e), 4'(f)};
  endfunction

  function automatic logic [35:0] actual();
    return {pw, pw_valid, busy, display5, display4, display3, display2, display1, display0};
  endfunction

  function automatic logic [35:0] m_expect();
    logic [23:0] d;
    case (m_phase)
      0:       d = dsp(15, 15, 15, 15, 15, 15);
      1, 2:    d = dsp(m_phase, 15, m_h / 10, m_h % 10, m_t, m_o);
      default: d = m_pass ? dsp(15, 15, 10, 11, 5, 5) : dsp(15, 15, 12, 11, 1, 13);
    endcase
    return {10'(m_pw), m_pwv, (m_phase != 0), d};
  endfunction

  task automatic m_reset();
    m_phase = 0; m_h = 0; m_t = 0; m_o = 0; m_first = 0;
    m_pw = 0; m_pwv = 0; m_pass = 0; m_dwell = 0;
    for (int i = 0; i < 4; i++) run[i] = 0;
    ev_q.delete();
  endtask

  task automatic m_step(input logic [3:0] ev, input bit en);
    int v;
    case (m_phase)
      0: if (ev[3] && en) begin
           m_phase = 1; m_h = 0; m_t = 0; m_o = 0;
         end
      1, 2: begin
        if (!en) begin
          m_phase = 0;
        end else if (ev[3]) begin
          v = m_h * 100 + m_t * 10 + m_o;
          if (m_phase == 1) begin
            m_first = v;
            if (v > 1023) begin
              m_phase = 3; m_pass = 0; m_dwell = 0;
            end else begin
              m_phase = 2; m_h = 0; m_t = 0; m_o = 0;
            end
          end else begin
            m_pass = (v == m_first);
            if (m_pass) begin
              m_pw = v; m_pwv = 1;
            end
            m_phase = 3; m_dwell = 0;
          end
        end else begin
          if (ev[2]) m_h = (m_h + 1) % 11;
          if (ev[1]) m_t = (m_t + 1) % 10;
          if (ev[0]) m_o = (m_o + 1) % 10;
        end
      end
      default: begin
        m_dwell++;
        if (m_dwell == RES) m_phase = 0;
      end
    endcase
  endtask

  task automatic check(input string name, input logic [35:0] act_v, input logic [35:0] exp_v);
    n_checks++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL %s: got pw/valid/busy/disp=%h required %h", name, act_v, exp_v);
  endtask

  // One clock: drive pins (low-mask), advance model, compare after the edge.
  task automatic cyc(input logic [3:0] low, input bit en);
    logic [3:0] evn, due;
    key0 = ~low[0]; key1 = ~low[1]; key2 = ~low[2]; key3 = ~low[3];
    enroll_en = en;
    for (int i = 0; i < 4; i++) begin
      run[i] = low[i] ? run[i] + 1 : 0;
      evn[i] = (run[i] == HOLD);
    end
    // Press recognised on pin sample c is acted on at the edge closing cycle c+3.
    ev_q.push_back(evn);
    if (ev_q.size() > 3) due = ev_q.pop_front();
    else due = 4'b0;
    m_step(due, en);
    @(posedge CLOCK_50); #1;
    n_cyc++;
    check($sformatf("cycle%0d", n_cyc), actual(), m_expect());
  endtask

  // Asynchronous reset dropped mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2;
    key0 = 1'b1; key1 = 1'b1; key2 = 1'b1; key3 = 1'b1;
    reset_n = 1'b0;
    #1;
    check("reset_async", actual(), {10'd0, 1'b0, 1'b0, 24'hFFFFFF});
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset_n = 1'b1;
    m_reset();
  endtask

  // ---- directed table ----
  typedef struct {
    logic [3:0]  kmask;
    int          low;
    int          gap;
    bit          en;
    bit          rst;
    logic [9:0]  pw;
    bit          pwv;
    bit          busy;
    logic [23:0] disp;
  } row_t;

  row_t tbl[$];

  task automatic add(input logic [3:0] k, input int low, input int gap, input bit en,
                     input logic [9:0] p, input bit pv, input bit b, input logic [23:0] d);
    row_t r;
    r.kmask = k; r.low = low; r.gap = gap; r.en = en; r.rst = 1'b0;
    r.pw = p; r.pwv = pv; r.busy = b; r.disp = d;
    tbl.push_back(r);
  endtask

  task automatic add_rst();
    row_t r;
    r.kmask = 4'b0; r.low = 0; r.gap = 0; r.en = 1'b1; r.rst = 1'b1;
    r.pw = 10'd0; r.pwv = 1'b0; r.busy = 1'b0; r.disp = 24'hFFFFFF;
    tbl.push_back(r);
  endtask

  task automatic add_digits(input int ph, input int h, input int t, input int o,
                            input logic [9:0] p, input bit pv);
    for (int i = 1; i <= h; i++)
      add(4'b0100, 5, 4, 1, p, pv, 1, dsp(ph, 15, (i % 11) / 10, (i % 11) % 10, 0, 0));
    for (int i = 1; i <= t; i++)
      add(4'b0010, 5, 4, 1, p, pv, 1, dsp(ph, 15, (h % 11) / 10, (h % 11) % 10, i % 10, 0));
    for (int i = 1; i <= o; i++)
      add(4'b0001, 5, 4, 1, p, pv, 1, dsp(ph, 15, (h % 11) / 10, (h % 11) % 10, t % 10, i % 10));
  endtask

  task automatic run_row(input int idx, input row_t r);
    if (r.rst) begin
      do_reset();
    end else begin
      for (int i = 0; i < r.low; i++) cyc(r.kmask, r.en);
      for (int i = 0; i < r.gap; i++) cyc(4'b0, r.en);
    end
    check($sformatf("row%0d", idx), actual(), {r.pw, r.pwv, r.busy, r.disp});
  endtask

  initial begin
    logic [23:0] blank, pass_d, fail_d, e1, e2;
    int          rem[4];
    bit          en_r;

    blank  = dsp(15, 15, 15, 15, 15, 15);
    pass_d = dsp(15, 15, 10, 11, 5, 5);
    fail_d = dsp(15, 15, 12, 11, 1, 13);
    e1     = dsp(1, 15, 0, 0, 0, 0);
    e2     = dsp(2, 15, 0, 0, 0, 0);

    // Enroll 123 twice -> pass.
    add(4'b1000, 5, 4, 1, 0, 0, 1, e1);
    add_digits(1, 1, 2, 3, 0, 0);
    add(4'b1000, 5, 4, 1, 0, 0, 1, e2);
    add_digits(2, 1, 2, 3, 0, 0);
    add(4'b1000, 5, 4, 1, 123, 1, 1, pass_d);
    add(4'b0000, 0, 10, 1, 123, 1, 0, blank);
    // 123 then 124 -> fail, pw kept.
    add(4'b1000, 5, 4, 1, 123, 1, 1, e1);
    add_digits(1, 1, 2, 3, 123, 1);
    add(4'b1000, 5, 4, 1, 123, 1, 1, e2);
    add_digits(2, 1, 2, 4, 123, 1);
    add(4'b1000, 5, 4, 1, 123, 1, 1, fail_d);
    add(4'b0000, 0, 10, 1, 123, 1, 0, blank);
    // 1050 in the first entry -> immediate fail.
    add(4'b1000, 5, 4, 1, 123, 1, 1, e1);
    add_digits(1, 10, 5, 0, 123, 1);
    add(4'b1000, 5, 4, 1, 123, 1, 1, fail_d);
    add(4'b0000, 0, 10, 1, 123, 1, 0, blank);
    // Long hold counts once; hundreds wrap after 11 presses.
    add(4'b1000, 5, 4, 1, 123, 1, 1, e1);
    add(4'b0001, 50, 4, 1, 123, 1, 1, dsp(1, 15, 0, 0, 0, 1));
    for (int i = 1; i <= 11; i++)
      add(4'b0100, 5, 4, 1, 123, 1, 1, dsp(1, 15, (i % 11) / 10, (i % 11) % 10, 0, 1));
    add(4'b1000, 5, 4, 1, 123, 1, 1, e2);
    // enroll_en dropped in ENTER2 -> idle after one edge.
    add(4'b0000, 0, 1, 0, 123, 1, 0, blank);
    // Reset mid-entry wipes pw.
    add(4'b1000, 5, 4, 1, 123, 1, 1, e1);
    add_rst();
    // key3 together with a digit key: commit on pre-increment digits.
    add(4'b1000, 5, 4, 1, 0, 0, 1, e1);
    add(4'b1001, 5, 4, 1, 0, 0, 1, e2);
    add(4'b1010, 5, 4, 1, 0, 1, 1, pass_d);
    add(4'b0000, 0, 10, 1, 0, 1, 0, blank);

    m_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    reset_n = 1'b1;
    check("reset_vals", actual(), {10'd0, 1'b0, 1'b0, 24'hFFFFFF});
    cyc(4'b0, 1'b1);

    foreach (tbl[i]) run_row(i, tbl[i]);

    // Randomized key activity.
    for (int i = 0; i < 4; i++) rem[i] = 0;
    en_r = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      logic [3:0] m;
      for (int i = 0; i < 4; i++) begin
        if (rem[i] > 0) rem[i]--;
        else if ($urandom_range(0, (i == 3) ? 40 : 12) == 0) rem[i] = int'($urandom_range(1, 9));
        m[i] = (rem[i] > 0);
      end
      if (en_r ? ($urandom_range(0, 300) == 0) : ($urandom_range(0, 20) == 0)) en_r = ~en_r;
      cyc(m, en_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
